branch_redirect_ctrl: RTL and testbench

Sequential controller for branch and jump resolution in the EX stage of the FyraVortex pipeline. It takes the resolved condition from a `branchCmp` sub-module and computes the target. On a taken control transfer it registers a redirect to fetch, holds it until fetch accepts, then flushes the wrong-path IF/ID and ID/EX contents for a programmable number of cycles. It is the only source of `redirect_valid` and the pipeline flush signals.

---
 rtl/fyra_pkg.sv | 21 ++
 rtl/branchCmp.sv | 26 ++
 rtl/branch_redirect_ctrl.sv | 135 +++++++++++++
 tb/tb_branch_redirect_ctrl.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/fyra_pkg.sv
// Shared types for the FyraVortex EX-stage branch redirect logic.
package fyra_pkg;

  localparam int unsigned FLUSH_CNT_W = 3;

  typedef enum logic [2:0] {
    BcEq  = 3'b000,
    BcNe  = 3'b001,
    BcLt  = 3'b100,
    BcGe  = 3'b101,
    BcLtu = 3'b110,
    BcGeu = 3'b111
  } bctrl_e;

  typedef enum logic [1:0] {
    RsIdle     = 2'd0,
    RsRedirect = 2'd1,
    RsFlush    = 2'd2
  } redir_state_e;

endpackage

// File: rtl/branchCmp.sv
// Combinational branch condition evaluator for the six funct3 branch codes.
module branchCmp
  import fyra_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [2:0]      bCtrl,
  input  logic [XLEN-1:0] r1,
  input  logic [XLEN-1:0] r2,
  output logic            cond
);

  always_comb begin
    cond = 1'b0;
    unique case (bCtrl)
      BcEq:    cond = (r1 == r2);
      BcNe:    cond = (r1 != r2);
      BcLt:    cond = ($signed(r1) < $signed(r2));
      BcGe:    cond = ($signed(r1) >= $signed(r2));
      BcLtu:   cond = (r1 < r2);
      BcGeu:   cond = (r1 >= r2);
      default: cond = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_redirect_ctrl.sv
// EX-stage branch/jump resolution: registered redirect handshake plus timed wrong-path flush.
// Optional BRANCH_STATS_EN adds stat_branches / stat_taken counters.
module branch_redirect_ctrl
  import fyra_pkg::*;
#(
  parameter int unsigned XLEN         = 32,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ex_valid,
  input  logic            ex_is_branch,
  input  logic            ex_is_jal,
  input  logic            ex_is_jalr,
  input  logic [2:0]      bCtrl,
  input  logic [XLEN-1:0] r1,
  input  logic [XLEN-1:0] r2,
  input  logic [XLEN-1:0] ex_pc,
  input  logic [XLEN-1:0] ex_imm,
  input  logic            fetch_ready,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  output logic            flush_ifid,
  output logic            flush_idex,
  output logic            ex_stall,
`ifdef BRANCH_STATS_EN
  output logic [XLEN-1:0] stat_branches,
  output logic [XLEN-1:0] stat_taken,
`endif
  output logic            misalign_exc
);

  redir_state_e           state_q, state_d;
  logic [FLUSH_CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0]        pc_q, pc_d;
  logic                   mis_q, mis_d;

  logic            cond;
  logic            is_cti;
  logic            taken;
  logic [XLEN-1:0] sum_pc, sum_r1, target;

  branchCmp #(.XLEN(XLEN)) u_cmp (
    .bCtrl (bCtrl),
    .r1    (r1),
    .r2    (r2),
    .cond  (cond)
  );

  assign is_cti = ex_valid & (ex_is_branch | ex_is_jal | ex_is_jalr);
  assign taken  = ex_valid & (ex_is_jal | ex_is_jalr | (ex_is_branch & cond));
  assign sum_pc = ex_pc + ex_imm;
  assign sum_r1 = r1 + ex_imm;
  assign target = ex_is_jalr ? (sum_r1 & {{(XLEN-1){1'b1}}, 1'b0}) : sum_pc;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pc_d    = pc_q;
    mis_d   = 1'b0;
    unique case (state_q)
      RsIdle: begin
        if (taken) begin
          if (target[1:0] == 2'b00) begin
            pc_d    = target;
            state_d = RsRedirect;
          end else begin
            mis_d = 1'b1;
          end
        end
      end
      RsRedirect: begin
        if (fetch_ready) begin
          cnt_d   = FLUSH_CNT_W'(FLUSH_CYCLES);
          state_d = RsFlush;
        end
      end
      RsFlush: begin
        // Leave on the final flush cycle so a new branch is accepted right after.
        cnt_d = cnt_q - 1'b1;
        if (cnt_q <= FLUSH_CNT_W'(1)) begin
          cnt_d   = '0;
          state_d = RsIdle;
        end
      end
      default: state_d = RsIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RsIdle;
      cnt_q   <= '0;
      pc_q    <= '0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pc_q    <= pc_d;
      mis_q   <= mis_d;
    end
  end

  assign redirect_valid = (state_q == RsRedirect);
  assign ex_stall       = (state_q == RsRedirect);
  assign flush_ifid     = (state_q == RsFlush);
  assign flush_idex     = (state_q == RsFlush);
  assign redirect_pc    = pc_q;
  assign misalign_exc   = mis_q;

`ifdef BRANCH_STATS_EN
  logic [XLEN-1:0] stat_br_q, stat_tk_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_br_q <= '0;
      stat_tk_q <= '0;
    end else begin
      if (state_q == RsIdle && is_cti) begin
        stat_br_q <= stat_br_q + 1'b1;
      end
      if (state_q == RsIdle && state_d == RsRedirect) begin
        stat_tk_q <= stat_tk_q + 1'b1;
      end
    end
  end

  assign stat_branches = stat_br_q;
  assign stat_taken    = stat_tk_q;
`else
  logic unused_cti;
  assign unused_cti = is_cti;
`endif

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Scoreboard bench for branch_redirect_ctrl: a behavioural reference pushes expected outputs
// per driven cycle; they are popped and compared after the clock edge.
module tb_branch_redirect_ctrl;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned FLUSH = 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            ex_valid, ex_is_branch, ex_is_jal, ex_is_jalr;
  logic [2:0]      bCtrl;
  logic [XLEN-1:0] r1, r2, ex_pc, ex_imm;
  logic            fetch_ready;
  logic            redirect_valid, flush_ifid, flush_idex, ex_stall, misalign_exc;
  logic [XLEN-1:0] redirect_pc;
`ifdef BRANCH_STATS_EN
  logic [XLEN-1:0] stat_branches, stat_taken;
`endif

  always #5 clk = ~clk;

  branch_redirect_ctrl #(.XLEN(XLEN), .FLUSH_CYCLES(FLUSH)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .ex_valid       (ex_valid),
    .ex_is_branch   (ex_is_branch),
    .ex_is_jal      (ex_is_jal),
    .ex_is_jalr     (ex_is_jalr),
    .bCtrl          (bCtrl),
    .r1             (r1),
    .r2             (r2),
    .ex_pc          (ex_pc),
    .ex_imm         (ex_imm),
    .fetch_ready    (fetch_ready),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .flush_ifid     (flush_ifid),
    .flush_idex     (flush_idex),
    .ex_stall       (ex_stall),
`ifdef BRANCH_STATS_EN
    .stat_branches  (stat_branches),
    .stat_taken     (stat_taken),
`endif
    .misalign_exc   (misalign_exc)
  );

  typedef struct {
    logic            rv;
    logic [XLEN-1:0] pc;
    logic            fl;
    logic            stall;
    logic            mis;
  } exp_t;

  exp_t exp_q[$];

  int n_vec  = 0;
  int n_miss = 0;

  // Reference model state
  int              m_st  = 0;  // 0 idle, 1 redirect, 2 flush
  int              m_cnt = 0;
  logic [XLEN-1:0] m_pc  = '0;
  logic [XLEN-1:0] m_br  = '0;
  logic [XLEN-1:0] m_tk  = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic bit ref_cond(input logic [2:0] c, input logic [XLEN-1:0] a,
                                  input logic [XLEN-1:0] b);
    case (c)
      3'b000:  return a == b;
      3'b001:  return a != b;
      3'b100:  return $signed(a) < $signed(b);
      3'b101:  return !($signed(a) < $signed(b));
      3'b110:  return a < b;
      3'b111:  return !(a < b);
      default: return 1'b0;
    endcase
  endfunction

  task automatic drive_cycle(input bit ev, input bit br, input bit jal, input bit jalr,
                             input logic [2:0] bc, input logic [XLEN-1:0] a,
                             input logic [XLEN-1:0] b, input logic [XLEN-1:0] pc,
                             input logic [XLEN-1:0] imm, input bit fr);
    exp_t            e, got;
    bit              tk;
    logic [XLEN-1:0] tgt;
    ex_valid = ev; ex_is_branch = br; ex_is_jal = jal; ex_is_jalr = jalr;
    bCtrl = bc; r1 = a; r2 = b; ex_pc = pc; ex_imm = imm; fetch_ready = fr;
    e.mis = 1'b0;
    if (m_st == 0) begin
      tk  = ev && (jal || jalr || (br && ref_cond(bc, a, b)));
      tgt = jalr ? ((a + imm) & ~32'd1) : (pc + imm);
      if (ev && (br || jal || jalr)) m_br = m_br + 1;
      if (tk) begin
        if (tgt[1:0] == 2'b00) begin
          m_st = 1; m_pc = tgt; m_tk = m_tk + 1;
        end else begin
          e.mis = 1'b1;
        end
      end
    end else if (m_st == 1) begin
      if (fr) begin
        m_st = 2; m_cnt = FLUSH;
      end
    end else begin
      m_cnt = m_cnt - 1;
      if (m_cnt == 0) m_st = 0;
    end
    e.rv = (m_st == 1); e.stall = (m_st == 1); e.fl = (m_st == 2); e.pc = m_pc;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", 64'd0, 64'd1);
    end else begin
      got = exp_q.pop_front();
      check("redirect_valid", 64'(redirect_valid), 64'(got.rv));
      check("redirect_pc", 64'(redirect_pc), 64'(got.pc));
      check("flush_ifid", 64'(flush_ifid), 64'(got.fl));
      check("flush_idex", 64'(flush_idex), 64'(got.fl));
      check("ex_stall", 64'(ex_stall), 64'(got.stall));
      check("misalign_exc", 64'(misalign_exc), 64'(got.mis));
    end
  endtask

  task automatic idle(input int n, input bit fr);
    for (int i = 0; i < n; i++) drive_cycle(0, 0, 0, 0, 3'b000, '0, '0, '0, '0, fr);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rv"}, 64'(redirect_valid), 64'd0);
    check({tag, "_pc"}, 64'(redirect_pc), 64'd0);
    check({tag, "_fi"}, 64'(flush_ifid), 64'd0);
    check({tag, "_fx"}, 64'(flush_idex), 64'd0);
    check({tag, "_stall"}, 64'(ex_stall), 64'd0);
    check({tag, "_mis"}, 64'(misalign_exc), 64'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    ex_valid = 0; ex_is_branch = 0; ex_is_jal = 0; ex_is_jalr = 0;
    bCtrl = '0; r1 = '0; r2 = '0; ex_pc = '0; ex_imm = '0; fetch_ready = 0;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;

    // BEQ taken: redirect next cycle to 0x120, then two flush cycles
    drive_cycle(1, 1, 0, 0, 3'b000, 32'd5, 32'd5, 32'h100, 32'h20, 1);
    check("beq_target", 64'(redirect_pc), 64'h120);
    check("beq_rv", 64'(redirect_valid), 64'd1);
    drive_cycle(0, 0, 0, 0, 3'b000, '0, '0, '0, '0, 1);
    check("beq_flush1", 64'(flush_ifid), 64'd1);
    idle(3, 1);

    // Signed vs unsigned compare of the same operands
    drive_cycle(1, 1, 0, 0, 3'b100, 32'hFFFF_FFFF, 32'd1, 32'h200, 32'h40, 1);
    check("blt_taken", 64'(redirect_valid), 64'd1);
    idle(3, 1);
    drive_cycle(1, 1, 0, 0, 3'b110, 32'hFFFF_FFFF, 32'd1, 32'h200, 32'h40, 1);
    check("bltu_not_taken", 64'(redirect_valid), 64'd0);
    idle(1, 1);

    // JALR targets: 0x1002 is misaligned, 0x1005 masks to aligned 0x1004
    drive_cycle(1, 0, 0, 1, 3'b000, 32'h1003, '0, 32'h40, 32'h0, 1);
    check("jalr_mis", 64'(misalign_exc), 64'd1);
    drive_cycle(1, 0, 0, 1, 3'b000, 32'h1005, '0, 32'h40, 32'h0, 1);
    check("jalr_mask", 64'(redirect_pc), 64'h1004);
    idle(3, 1);
    drive_cycle(1, 0, 1, 0, 3'b000, '0, '0, 32'h10, 32'h2, 1);
    check("jal_mis", 64'(misalign_exc), 64'd1);
    idle(1, 1);

    // BNE with fetch stalled 4 cycles; wrong-path JALs presented throughout
    drive_cycle(1, 1, 0, 0, 3'b001, 32'd1, 32'd2, 32'h300, 32'h80, 0);
    for (int i = 0; i < 4; i++) drive_cycle(1, 0, 1, 0, 3'b000, '0, '0, 32'h500, 32'h8, 0);
    check("bne_held_pc", 64'(redirect_pc), 64'h380);
    check("bne_held_stall", 64'(ex_stall), 64'd1);
    // Accept, flush with wrong-path JALs, then back-to-back JAL accepted right away
    for (int i = 0; i < 6; i++) drive_cycle(1, 0, 1, 0, 3'b000, '0, '0, 32'h500, 32'h8, 1);
    idle(3, 1);

    // Random mix of all condition codes, including unused encodings
    for (int i = 0; i < 60; i++) begin
      logic [2:0] bc;
      logic [XLEN-1:0] a, b, imm;
      int k;
      bc  = 3'($urandom_range(0, 7));
      a   = ($urandom_range(0, 3) == 0) ? 32'h8000_0000 : XLEN'($urandom_range(0, 6));
      b   = XLEN'($urandom_range(0, 6));
      imm = XLEN'($urandom_range(0, 15));
      k   = $urandom_range(0, 4);
      drive_cycle(k != 0, k == 1 || k == 2, k == 3, k == 4, bc, a, b,
                  XLEN'($urandom_range(0, 255)) << 2, imm, 1'($urandom_range(0, 1)));
    end
    idle(8, 1);

    // Asynchronous reset while flushing drops everything immediately
    drive_cycle(1, 1, 0, 0, 3'b101, 32'd3, 32'd3, 32'h600, 32'h4, 1);
    drive_cycle(0, 0, 0, 0, 3'b000, '0, '0, '0, '0, 1);
    check("pre_reset_flush", 64'(flush_idex), 64'd1);
    rst_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    m_st = 0; m_cnt = 0; m_pc = '0; m_br = '0; m_tk = '0;
    #1;
    rst_n = 1'b1;
    drive_cycle(1, 1, 0, 0, 3'b111, 32'd9, 32'd2, 32'h700, 32'h10, 1);
    check("post_reset_target", 64'(redirect_pc), 64'h710);
    idle(4, 1);

`ifdef BRANCH_STATS_EN
    check("stat_branches", 64'(stat_branches), 64'(m_br));
    check("stat_taken", 64'(stat_taken), 64'(m_tk));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
